sw_bank_debounce: RTL and testbench
===================================

# sw_bank_debounce

Multi-bit switch conditioner that sits directly upstream of the 12-bit dual-priority encoder. It synchronizes the raw slide-switch bank to `clk`, rejects mechanical bounce on the vector as a whole, and presents a stable `sw_db` vector to the encoder's request input. It also emits one-cycle change strobes, so downstream logic can react to a settled edit without comparing vectors itself.

## Interface

Parameters:
- `WIDTH`, default 12: number of switch bits.
- `N`, default 20: debounce counter width. The settle time is 2^N cycles, about 21 ms at 50 MHz. Simulation uses N=3.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `sw_in`  input  WIDTH  raw switch levels, asynchronous to `clk`.
- `sw_db`  output  WIDTH  debounced switch vector; feeds the encoder's `r`.
- `changed`  output  1  one-cycle pulse in the cycle `sw_db` takes a new value.
- `rise`  output  WIDTH  one-cycle per-bit pulse for bits that went 0→1 on that update.
- `fall`  output  WIDTH  one-cycle per-bit pulse for bits that went 1→0 on that update.
- `busy`  output  1  high while a candidate value is being timed (FSM in WAIT).

## Operation

Synchronizer:
- Two flops, `s1 <= sw_in`, then `s2 <= s1`.
- The FSM reads only `s2`.

Registers:
- `s1`, `s2`, candidate `cand[WIDTH]`, counter `cnt[N]`, `sw_db`, state.

IDLE state:
- If `s2 != sw_db`: set `cand <= s2`, `cnt <= 0`, go to WAIT.
- Otherwise stay in IDLE.

WAIT state (evaluated in this priority order):
1. `s2 != cand`: set `cand <= s2`, `cnt <= 0`, stay in WAIT. This is bounce, so the count restarts.
2. `cand == sw_db`: go to IDLE with no update. The input bounced back to the settled value.
3. `cnt == 2^N-1`: set `sw_db <= cand`, pulse `changed`, `rise <= cand & ~sw_db`, `fall <= ~cand & sw_db`, go to IDLE.
4. Otherwise: `cnt <= cnt + 1`.

Rules:
- Debouncing is whole-vector: any bit moving restarts the count for all bits. Bits that change together settle together in one update.
- `changed`, `rise` and `fall` are registered. They are high for exactly one cycle, concurrent with the first cycle `sw_db` shows the new value. Otherwise they are 0.
- `busy` = (state == WAIT), decoded from the state register.
- `cnt` never wraps. It is cleared on entry to WAIT and on any restart, and it stops at 2^N-1.

Reset (`reset` = 0, asynchronous):
- `s1`, `s2`, `cand`, `cnt` and `sw_db` go to 0.
- State goes to IDLE.
- `changed`, `rise`, `fall` and `busy` go to 0.

Reset behaviour:
- Reset asserted mid-WAIT abandons the candidate with no output pulse.
- On release, switches held high are reported by the normal path: a full debounce period, then `changed`, with `rise` set for those bits.

## Timing

- Let `sw_in` change and then stay stable, first sampled by `s1` at edge k.
- `s2` updates at edge k+1.
- The FSM enters WAIT at edge k+2 with `cnt` = 0.
- `sw_db`, `changed`, `rise` and `fall` update at edge k+2+2^N. Total latency is 2^N+2 cycles; with N=3 that is 10 cycles.
- A change of `s2` on any WAIT cycle, including the terminal-count cycle, takes rule 1: no update, and timing restarts from that edge.
- Back-to-back edits are accepted: a new difference seen in IDLE on the cycle right after an update enters WAIT on the next edge.
- Throughput: at most one `sw_db` update per 2^N+1 cycles.

## Test plan

All scenarios use N=3, WIDTH=12.

1. **Reset values.** Drive `reset`=0 with `sw_in`=12'hFFF. Required: all outputs 0 and `busy`=0 throughout reset.
2. **Clean change.** Release reset with `sw_in`=0, then set `sw_in`=12'h801 at edge k. Required: `busy` rises after edge k+2. At edge k+10, `sw_db`=12'h801, `changed`=1, `rise`=12'h801 and `fall`=0. At edge k+11, `changed`=0.
3. **Bounce.** From `sw_db`=12'h801, toggle bit 4 every 3 cycles five times, then leave it at 1. Required: no `changed` pulse during the toggling. Exactly one update to 12'h811, occurring 10 cycles after the last toggle sample, with `rise`=12'h010.
4. **Glitch back.** From `sw_db`=12'h811, drop bit 0 for 2 cycles, then restore it. Required: `busy` pulses high, returns to IDLE, `sw_db` stays 12'h811 and `changed` never asserts.
5. **Multi-bit mixed change.** Change 12'h811 to 12'h0F0 in one edge. Required: a single update with `rise`=12'h0E0, `fall`=12'h801 and `changed` high for one cycle.
6. **Reset mid-WAIT.** Assert `reset` 4 cycles into WAIT, release it 2 cycles later with `sw_in`=12'h003. Required: no pulse during reset. After release, `sw_db`=12'h003 with `rise`=12'h003 after 10 cycles.

Source files
------------

// File: rtl/sw_bank_debounce.sv
// Switch-bank conditioner: two-flop synchronizer, whole-vector debounce FSM,
// and registered one-cycle change/rise/fall strobes for the downstream encoder.
module sw_bank_debounce #(
  parameter int WIDTH = 12,
  parameter int N     = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q;
  logic [N-1:0]     cnt_q;
  logic [WIDTH-1:0] db_q;
  logic             changed_q;
  logic [WIDTH-1:0] rise_q, fall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_in;
      s2_q <= s1_q;
    end
  end

  // Strobes default low every cycle; only the terminal-count update raises them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
      changed_q <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      changed_q <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (s2_q != db_q) begin
            cand_q  <= s2_q;
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (s2_q != cand_q) begin
            cand_q <= s2_q;
            cnt_q  <= '0;
          end else if (cand_q == db_q) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '1) begin
            db_q      <= cand_q;
            changed_q <= 1'b1;
            rise_q    <= cand_q & ~db_q;
            fall_q    <= ~cand_q & db_q;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sw_db   = db_q;
  assign changed = changed_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign busy    = (state_q == ST_WAIT);

endmodule

// File: tb/tb_sw_bank_debounce.sv
// Scoreboard bench for sw_bank_debounce: a run-length reference model predicts
// each settled update; a negedge monitor compares every cycle's outputs.
module tb_sw_bank_debounce;

  localparam int WIDTH  = 12;
  localparam int N      = 3;
  localparam int SETTLE = (1 << N) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] sw_in = '0;
  logic [WIDTH-1:0] sw_db;
  logic             changed;
  logic [WIDTH-1:0] rise, fall;
  logic             busy;

  int checks = 0;
  int errors = 0;

  sw_bank_debounce #(.WIDTH(WIDTH), .N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .sw_in  (sw_in),
    .sw_db  (sw_db),
    .changed(changed),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Expected update: {new sw_db, rise, fall}
  logic [3*WIDTH-1:0] sb_q[$];

  // Reference model: the debounced value follows the synchronized input once it
  // has been seen unchanged on SETTLE consecutive edges and differs from sw_db.
  logic [WIDTH-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_db = '0;
  logic             m_busy = 1'b0;
  int               m_run = 0;

  always @(posedge clk) begin
    logic [WIDTH-1:0] smp, db_before;
    logic             was_busy, upd;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_db = '0;
      m_busy = 1'b0; m_run = 0;
      sb_q.delete();
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = sw_in;
      if (smp == m_prev) begin
        if (m_run < 1000) m_run = m_run + 1;
      end else begin
        m_run = 1;
      end
      db_before = m_db;
      was_busy  = m_busy;
      upd       = 1'b0;
      if (smp != m_db && m_run == SETTLE) begin
        sb_q.push_back({smp, smp & ~db_before, ~smp & db_before});
        m_db = smp;
        upd  = 1'b1;
      end
      m_busy = !upd && ((smp != db_before) || (was_busy && smp != m_prev));
      m_prev = smp;
    end
  end

  int pulses = 0;

  always @(negedge clk) begin
    logic [3*WIDTH-1:0] exp_v;
    checks++;
    if (!reset) begin
      if (sw_db !== '0 || changed !== 1'b0 || rise !== '0 || fall !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs t=%0t got db=%h ch=%b r=%h f=%h busy=%b want all 0",
                 $time, sw_db, changed, rise, fall, busy);
      end
    end else begin
      if (sw_db !== m_db || busy !== m_busy) begin
        errors++;
        $display("FAIL state t=%0t got db=%h busy=%b want db=%h busy=%b",
                 $time, sw_db, busy, m_db, m_busy);
      end
      checks++;
      if (changed === 1'b1) begin
        pulses++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_change t=%0t got db=%h r=%h f=%h want no pulse",
                   $time, sw_db, rise, fall);
        end else begin
          exp_v = sb_q.pop_front();
          if ({sw_db, rise, fall} !== exp_v) begin
            errors++;
            $display("FAIL update t=%0t got db=%h r=%h f=%h want db=%h r=%h f=%h",
                     $time, sw_db, rise, fall, exp_v[3*WIDTH-1:2*WIDTH],
                     exp_v[2*WIDTH-1:WIDTH], exp_v[WIDTH-1:0]);
          end
        end
      end else begin
        if (sb_q.size() != 0) begin
          exp_v = sb_q.pop_front();
          errors++;
          $display("FAIL missing_change t=%0t got changed=0 want pulse db=%h", $time,
                   exp_v[3*WIDTH-1:2*WIDTH]);
        end else if (rise !== '0 || fall !== '0) begin
          errors++;
          $display("FAIL idle_strobes t=%0t got r=%h f=%h want 0", $time, rise, fall);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int p0;
    logic [WIDTH-1:0] v;
    // Reset with switches high
    reset = 1'b0; sw_in = 12'hFFF;
    cyc(5);
    // Clean change
    sw_in = '0; reset = 1'b1;
    cyc(5);
    sw_in = 12'h801;
    cyc(14);
    // Bounce on bit 4, ending high
    for (int i = 0; i < 5; i++) begin
      sw_in = sw_in ^ 12'h010;
      cyc(3);
    end
    cyc(12);
    // Glitch back on bit 0
    p0 = pulses;
    sw_in = 12'h810;
    cyc(2);
    sw_in = 12'h811;
    cyc(14);
    checks++;
    if (pulses != p0 || sw_db !== 12'h811) begin
      errors++;
      $display("FAIL glitch_back got pulses=%0d db=%h want pulses=%0d db=811",
               pulses - p0, sw_db, 0);
    end
    // Multi-bit mixed change
    sw_in = 12'h0F0;
    cyc(14);
    // Reset mid-WAIT
    sw_in = 12'h0F3;
    cyc(6);
    reset = 1'b0;
    cyc(2);
    sw_in = 12'h003; reset = 1'b1;
    cyc(16);
    checks++;
    if (sw_db !== 12'h003) begin
      errors++;
      $display("FAIL after_reset got db=%h want 003", sw_db);
    end
    // Randomized edits, bounces, holds and occasional resets
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: sw_in = WIDTH'($urandom);
        3, 4, 5: begin
          v = '0;
          v[$urandom_range(0, WIDTH-1)] = 1'b1;
          sw_in = sw_in ^ v;
        end
        6: begin
          if ($urandom_range(0, 3) == 0) begin
            reset = 1'b0;
            cyc($urandom_range(1, 3));
            reset = 1'b1;
          end
        end
        default: ;
      endcase
      cyc($urandom_range(1, 14));
    end
    cyc(SETTLE + 4);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
